// File: rtl/if_feeder_pkg.sv
// if_feeder_pkg
//   Types and constants shared by the IF stream feeder and the IF buffer
//   consumer.
//   - feed_state_t: feeder control states.
//   - SOR_BIT / EOR_BIT: tag positions in a tagged IF word at the default
//     sample width.
//   - sor_bit() / eor_bit(): the same positions for any sample width w.
//     The tagged word is {SOR, EOR, sample[w-1:0]}.
package if_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  localparam int IF_W_DEFAULT = 8;
  localparam int SOR_BIT      = IF_W_DEFAULT + 1;
  localparam int EOR_BIT      = IF_W_DEFAULT;

  function automatic int sor_bit(input int w);
    return w + 1;
  endfunction

  function automatic int eor_bit(input int w);
    return w;
  endfunction

endpackage

// File: rtl/if_feed_skid.sv
// if_feed_skid
//   Two-entry synchronous FIFO holding tagged IF words between the memory
//   read return and the IF buffer write port.
//   Ports:
//     clk, rst : clock and synchronous active-high reset.
//                Reset empties the FIFO and zeroes its storage.
//     push     : write din this cycle. The caller never pushes while full.
//     pop      : drop the head this cycle. The caller never pops while empty.
//     din      : tagged word to store.
//     count    : number of stored entries (0..2).
//     head     : oldest stored entry.
module if_feed_skid
  import if_feeder_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage is cleared as well, so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stream_feeder.sv
// if_stream_feeder
//   Reads a num_rows x row_len block of IF samples from a word-addressed
//   memory with one-cycle read latency. Each sample is tagged with
//   start-of-row / end-of-row flags and pushed into the IF FIFO, honouring
//   IF_full back-pressure.
//   Ports:
//     clk, rst   : clock and synchronous active-high reset.
//     start      : launch request, sampled only while idle.
//     base_addr  : first sample address. Latched at launch.
//     row_len    : samples per row. Latched at launch.
//     num_rows   : number of rows. Latched at launch.
//     mem_ren    : memory read strobe.
//     mem_addr   : read address while mem_ren is high, otherwise 0.
//     mem_rdata  : read data, valid one cycle after mem_ren.
//     IF_full    : IF FIFO full.
//     IF_wen     : IF FIFO write enable.
//     IF_din     : tagged word {SOR, EOR, sample}.
//     busy       : high from the cycle after launch through the done cycle.
//     done       : one-cycle pulse after the last word has been written.
module if_stream_feeder
  import if_feeder_pkg::*;
#(
  parameter int IF_SCRATCH_WIDTH = 8,
  parameter int IF_ADDR_LEN      = 8,
  parameter int MEM_ADDR_LEN     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MEM_ADDR_LEN-1:0]     base_addr,
  input  logic [IF_ADDR_LEN-1:0]      row_len,
  input  logic [IF_ADDR_LEN-1:0]      num_rows,
  output logic                        mem_ren,
  output logic [MEM_ADDR_LEN-1:0]     mem_addr,
  input  logic [IF_SCRATCH_WIDTH-1:0] mem_rdata,
  input  logic                        IF_full,
  output logic                        IF_wen,
  output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W   = 2 * IF_ADDR_LEN;
  localparam int TAG_W   = IF_SCRATCH_WIDTH + 2;
  localparam int SOR_POS = sor_bit(IF_SCRATCH_WIDTH);
  localparam int EOR_POS = eor_bit(IF_SCRATCH_WIDTH);

  feed_state_t             state;
  logic [MEM_ADDR_LEN-1:0] base_q;
  logic [IF_ADDR_LEN-1:0]  row_len_q;
  logic [IF_ADDR_LEN-1:0]  col_q;
  logic [CNT_W-1:0]        total_q;
  logic [CNT_W-1:0]        issue_cnt_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    vld_p0;
  logic                    sor_p0;
  logic                    eor_p0;
  logic                    vld_p1;
  logic                    sor_p1;
  logic                    eor_p1;
  logic [TAG_W-1:0]        word_p1;

  logic [1:0]              skid_count;
  logic [TAG_W-1:0]        skid_head;
  logic [1:0]              occupancy;
  logic                    last_issue;
  logic                    drain_ok;
  logic                    degenerate;

  // ---- p0: read issue ----
  assign IF_wen     = (skid_count != 2'd0) && !IF_full;
  // Occupancy also counts the read in flight. A word leaving this cycle
  // frees a slot, so issue can continue at one word per cycle.
  assign occupancy  = skid_count + {1'b0, vld_p1};
  assign vld_p0     = (state == RUN) && (issue_cnt_q != total_q) &&
                      ((occupancy < 2'd2) || IF_wen);
  assign sor_p0     = (col_q == '0);
  assign eor_p0     = (col_q == row_len_q - IF_ADDR_LEN'(1));
  assign last_issue = vld_p0 && (issue_cnt_q == total_q - CNT_W'(1));
  assign mem_ren    = vld_p0;
  assign mem_addr   = vld_p0 ? (base_q + MEM_ADDR_LEN'(issue_cnt_q)) : '0;
  assign degenerate = (row_len == '0) || (num_rows == '0);
  // Done may follow once nothing is in flight and this cycle's write
  // (if any) empties the skid.
  assign drain_ok   = !vld_p1 &&
                      ((skid_count == 2'd0) || ((skid_count == 2'd1) && IF_wen));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_cnt_q <= '0;
      col_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            row_len_q   <= row_len;
            total_q     <= CNT_W'(row_len) * CNT_W'(num_rows);
            issue_cnt_q <= '0;
            col_q       <= '0;
            busy_q      <= 1'b1;
            // An empty block passes through DRAIN, which is trivially
            // satisfied. This gives one busy cycle before the done cycle.
            state       <= degenerate ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (vld_p0) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            col_q       <= eor_p0 ? '0 : col_q + IF_ADDR_LEN'(1);
            if (last_issue) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p1: read data returns, joined with its tags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    sor_p1 <= sor_p0;
    eor_p1 <= eor_p0;
  end

  always_comb begin
    word_p1                          = '0;
    word_p1[IF_SCRATCH_WIDTH-1:0]    = mem_rdata;
    word_p1[SOR_POS]                 = sor_p1;
    word_p1[EOR_POS]                 = eor_p1;
  end

  // ---- p2: skid buffer feeding the IF FIFO ----
  if_feed_skid #(
    .WIDTH (TAG_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .pop   (IF_wen),
    .din   (word_p1),
    .count (skid_count),
    .head  (skid_head)
  );

  assign IF_din = skid_head;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
